// File: rtl/anchor_sched_pkg.sv
// Shared definitions for the anchor-filter chunk sequencer.
// Contents:
//   sched_state_t  - sequencer states
//   DEFAULT_STRIDE - default anchor address stride of the filter engine
//   sat_add        - saturating add of two counts of a given width (<= 64)
package anchor_sched_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ACCUM,
        FINISH,
        ERR
    } sched_state_t;

    localparam int DEFAULT_STRIDE = 10;

    // Adds two unsigned counts and clamps the result to the all-ones value
    // of a 'width'-bit word. Callers zero-extend into and truncate out of
    // the 64-bit interface.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [64:0] sum;
        logic [64:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = (65'd1 << width) - 65'd1;
        return (sum > limit) ? limit[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/sched_watchdog.sv
// Watchdog counter for the engine wait phase.
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   clear    - restart the count from zero
//   enable   - count one waited cycle
//   timeout  - high on the cycle in which the count reaches TIMEOUT_CYCLES
module sched_watchdog #(
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Count holds the number of cycles already waited, so the flag is raised
    // during the TIMEOUT_CYCLES-th waiting cycle. The count parks there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + CW'(1);
        end
    end

    assign timeout = (count == LAST);

endmodule

// File: rtl/anchor_filter_sched.sv
// Sequencer that walks one anchor-filter engine over a host-supplied anchor
// address range in fixed-size chunks and accumulates the engine counts.
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   cfg_start / cfg_abort            - host job request / abandon
//   cfg_range_start / cfg_range_end  - inclusive job address range
//   cfg_distance_thr / cfg_num_thr   - thresholds forwarded to the engine
//   busy, done, error                - job status (done is a 1-cycle pulse)
//   total_count, chunk_index         - running total and chunks completed
//   eng_start, eng_addr_*, eng_*_thr - engine command interface
//   eng_done, eng_count              - engine level done and its result
module anchor_filter_sched
    import anchor_sched_pkg::*;
#(
    parameter int ANCHOR_ADDR_WIDTH = 7,
    parameter int STRIDE            = DEFAULT_STRIDE,
    parameter int CHUNK_SIZE        = 40,
    parameter int CNT_WIDTH         = 32,
    parameter int TIMEOUT_CYCLES    = 4095
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_abort,
    input  logic [ANCHOR_ADDR_WIDTH-1:0] cfg_range_start,
    input  logic [ANCHOR_ADDR_WIDTH-1:0] cfg_range_end,
    input  logic [15:0]                  cfg_distance_thr,
    input  logic [15:0]                  cfg_num_thr,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [CNT_WIDTH-1:0]         total_count,
    output logic [7:0]                   chunk_index,
    output logic                         eng_start,
    output logic [ANCHOR_ADDR_WIDTH-1:0] eng_addr_start,
    output logic [ANCHOR_ADDR_WIDTH-1:0] eng_addr_end,
    output logic [15:0]                  eng_distance_thr,
    output logic [15:0]                  eng_num_thr,
    input  logic                         eng_done,
    input  logic [CNT_WIDTH-1:0]         eng_count
);

    localparam int AW = ANCHOR_ADDR_WIDTH;
    localparam int EW = AW + 1;
    localparam logic [EW-1:0] SPAN = EW'(CHUNK_SIZE - STRIDE);
    localparam logic [EW-1:0] STEP = EW'(STRIDE);

    sched_state_t state, next_state;

    logic [AW-1:0]        range_end_q;
    logic [CNT_WIDTH-1:0] eng_count_q;
    logic                 accum_first;
    logic                 bad_done_q;
    logic                 wd_timeout;
    logic                 range_ok;
    logic                 last_chunk;
    logic [EW-1:0]        next_chunk_addr;
    logic [EW-1:0]        launch_addr;
    logic [EW-1:0]        launch_limit;
    logic [EW-1:0]        span_end;
    logic [AW-1:0]        launch_end;

    sched_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == LAUNCH),
        .enable (state == WAIT),
        .timeout(wd_timeout)
    );

    // Address math is one bit wider than the SRAM address so stepping past
    // the top of the address space never wraps back into range.
    assign range_ok        = (cfg_range_start <= cfg_range_end);
    assign next_chunk_addr = {1'b0, eng_addr_end} + STEP;
    assign last_chunk      = (next_chunk_addr > {1'b0, range_end_q});

    // Bounds of the chunk about to be launched: the first chunk comes
    // straight from the host inputs, later ones from the previous chunk end.
    always_comb begin
        launch_addr  = next_chunk_addr;
        launch_limit = {1'b0, range_end_q};
        if (state == IDLE) begin
            launch_addr  = {1'b0, cfg_range_start};
            launch_limit = {1'b0, cfg_range_end};
        end
        span_end   = launch_addr + SPAN;
        launch_end = (span_end < launch_limit) ? span_end[AW-1:0]
                                               : launch_limit[AW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. An abort from any active state returns to IDLE;
    // in IDLE a simultaneous abort is ignored so a start still wins.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (cfg_start && range_ok) next_state = LAUNCH;
            LAUNCH: next_state = WAIT;
            WAIT: begin
                if (eng_done) begin
                    next_state = ACCUM;
                end else if (wd_timeout) begin
                    next_state = ERR;
                end
            end
            ACCUM: begin
                // Relaunching only after eng_done drops guarantees the engine
                // has retired the previous chunk before seeing a new start.
                if (!eng_done) begin
                    next_state = last_chunk ? FINISH : LAUNCH;
                end
            end
            FINISH:  next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if ((state != IDLE) && cfg_abort) begin
            next_state = IDLE;
        end
    end

    // Job registers: configuration latch, chunk bounds, count capture,
    // accumulation and the sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_end_q      <= '0;
            eng_count_q      <= '0;
            accum_first      <= 1'b0;
            bad_done_q       <= 1'b0;
            error            <= 1'b0;
            total_count      <= '0;
            chunk_index      <= '0;
            eng_addr_start   <= '0;
            eng_addr_end     <= '0;
            eng_distance_thr <= '0;
            eng_num_thr      <= '0;
        end else begin
            bad_done_q  <= 1'b0;
            accum_first <= (state == WAIT) && (next_state == ACCUM);

            if ((state == IDLE) && cfg_start) begin
                total_count <= '0;
                chunk_index <= '0;
                if (range_ok) begin
                    range_end_q      <= cfg_range_end;
                    eng_distance_thr <= cfg_distance_thr;
                    eng_num_thr      <= cfg_num_thr;
                    error            <= 1'b0;
                end else begin
                    error      <= 1'b1;
                    bad_done_q <= 1'b1;
                end
            end

            if (next_state == LAUNCH) begin
                eng_addr_start <= launch_addr[AW-1:0];
                eng_addr_end   <= launch_end;
            end

            if ((state == WAIT) && eng_done) begin
                eng_count_q <= eng_count;
            end

            if ((state == ACCUM) && accum_first) begin
                total_count <= CNT_WIDTH'(sat_add(64'(total_count), 64'(eng_count_q), CNT_WIDTH));
                if (chunk_index != 8'hFF) begin
                    chunk_index <= chunk_index + 8'd1;
                end
            end

            if (next_state == ERR) begin
                error <= 1'b1;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign eng_start = (state == LAUNCH) && !cfg_abort;
    assign done      = bad_done_q || (((state == FINISH) || (state == ERR)) && !cfg_abort);

endmodule

// File: doc/anchor_filter_sched.md
Name: anchor_filter_sched

Overview:
Sequencer that drives one anchor-filter engine (level-0 neighbour-count filter) over a large anchor address range by splitting it into fixed-size chunks.
- Per chunk: issues a start pulse with chunk bounds and thresholds, waits for the engine's done, and accumulates the engine's effective-anchor count.
- Host side: start/abort/done handshake plus a running total.
- Sits between the host configuration registers and the filter engine.

Parameters:
ANCHOR_ADDR_WIDTH, 7, anchor SRAM address width (engine address ports)
STRIDE, 10, anchor address stride the engine walks with
CHUNK_SIZE, 40, addresses per chunk; multiple of STRIDE, >= STRIDE
CNT_WIDTH, 32, width of engine count and accumulated total
TIMEOUT_CYCLES, 4095, max cycles waiting for eng_done before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cfg_start  in  1  one-cycle request to start a job; ignored while busy
cfg_abort  in  1  abandon current job
cfg_range_start  in  ANCHOR_ADDR_WIDTH  first anchor address of job
cfg_range_end  in  ANCHOR_ADDR_WIDTH  last anchor address of job, inclusive
cfg_distance_thr  in  16  fp16 distance threshold, passed through
cfg_num_thr  in  16  neighbour-count threshold, passed through
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end (normal or error)
error  out  1  sticky job error flag
total_count  out  CNT_WIDTH  accumulated effective anchors
chunk_index  out  8  chunks completed in current job
eng_start  out  1  one-cycle start pulse to engine
eng_addr_start  out  ANCHOR_ADDR_WIDTH  chunk first address
eng_addr_end  out  ANCHOR_ADDR_WIDTH  chunk last address
eng_distance_thr  out  16  latched cfg_distance_thr
eng_num_thr  out  16  latched cfg_num_thr
eng_done  in  1  engine done, level
eng_count  in  CNT_WIDTH  engine effective-anchor count, valid while eng_done=1

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; internal registers 0.
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Address arithmetic is done in ANCHOR_ADDR_WIDTH+1 bits so no comparison wraps.
- Chunk end = min(cur + CHUNK_SIZE - STRIDE, range_end).
- State IDLE: busy=0.
  - cfg_start=1 with range_start<=range_end: latch range and thresholds; cur=range_start; total_count=0; chunk_index=0; error=0; go LAUNCH.
  - cfg_start=1 with range_start>range_end: error=1, done pulse next cycle, total_count=0; stay IDLE.
- State LAUNCH: eng_start=1 for exactly this cycle.
  - eng_addr_start=cur and eng_addr_end=chunk end are registered and held stable until the next LAUNCH.
  - Go WAIT; watchdog cleared.
- State WAIT: watchdog increments each cycle.
  - eng_done=1: capture eng_count; go ACCUM.
  - Watchdog reaches TIMEOUT_CYCLES before eng_done: go ERR.
  - eng_done and timeout in the same cycle: eng_done wins.
- State ACCUM:
  - Cycle 1: total_count += captured count, saturating at all-ones; chunk_index += 1 (saturate 255).
  - Then wait until eng_done=0; this handshake guarantees the engine has retired before the next start.
  - If chunk_end + STRIDE > range_end: go FINISH. Else cur = chunk_end + STRIDE; go LAUNCH.
- State FINISH: done=1 one cycle; go IDLE.
  - total_count, chunk_index and eng_* outputs hold until the next accepted cfg_start.
- State ERR: error=1 (sticky until next accepted cfg_start); done=1 one cycle; go IDLE.
- busy=1 in LAUNCH, WAIT, ACCUM, FINISH, ERR.
- cfg_abort=1 in any non-IDLE state:
  - next state IDLE; no done pulse, no eng_start that cycle.
  - total_count keeps its partial value; error unchanged.
- cfg_abort and cfg_start together in IDLE: abort ignored, start accepted.
- Minimum latency: start to first eng_start = 1 cycle. Per chunk overhead = 3 cycles plus engine time.

Decomposition:
- Package anchor_sched_pkg: state enum (IDLE, LAUNCH, WAIT, ACCUM, FINISH, ERR), STRIDE default, saturating-add function.
- One sub-module, sched_watchdog: counter with clear/enable and timeout flag, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Range 0..90, CHUNK_SIZE 40: eng_count 3,5,2 -> eng_start x3 with bounds [0,30],[40,70],[80,90]; total_count=10; chunk_index=3; one done pulse; error=0.
- Range 120..127 (7-bit addresses): chunk end clamps to 127 -> single chunk [120,127]; finish without wrap; done pulse.
- cfg_range_start=50, cfg_range_end=20 -> no eng_start; error=1; done pulse; total_count=0.
- eng_done never asserted -> after 4095 WAIT cycles: error=1, done pulse, busy drops.
- cfg_abort during second WAIT (counts 7 then pending) -> IDLE next cycle, total_count=7, no done; new cfg_start clears total_count and error.
- eng_count=0xFFFFFFF0 then 0x20 -> total_count saturates at 0xFFFFFFFF. Separately, eng_done held high 5 cycles after a chunk -> next eng_start only after eng_done falls.
